// File: rtl/hub75_pkg.sv
// rtl/hub75_pkg.sv - shared geometry and colour constants for the HUB75 capture slice
package hub75_pkg;

  localparam int SCREEN_WIDTH   = 64;
  localparam int SCREEN_WIDTH_B = 7;
  localparam int SCAN_ROWS      = 16;
  localparam int TOTAL_ROWS     = 2 * SCAN_ROWS;
  localparam int ROW_BITS       = 3 * SCREEN_WIDTH;

  typedef enum logic [1:0] {
    COL_B = 2'd0,
    COL_G = 2'd1,
    COL_R = 2'd2
  } colour_e;

  // rd_data is {R,G,B}; bit k of each slice is column k
  localparam int OFS_B = 0;
  localparam int OFS_G = SCREEN_WIDTH;
  localparam int OFS_R = 2 * SCREEN_WIDTH;

endpackage

// File: rtl/hub75_edge_sync.sv
// rtl/hub75_edge_sync.sv - 2-FF synchronizer with registered rise/fall pulses
module hub75_edge_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s2_q, rise_q, fall_q;
  logic rise_d, fall_d;

  // Pulses are taken one stage early so they line up with level_o and the data buses
  always_comb begin
    rise_d = s1_q & ~s2_q;
    fall_d = ~s1_q & s2_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q   <= RESET_VAL;
      s2_q   <= RESET_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= pin_i;
      s2_q   <= s1_q;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign level_o = s2_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/hub75_capture.sv
// rtl/hub75_capture.sv - rebuilds the HUB75 panel image from the oversampled panel pins
// Also measures OE-low windows and flags rows latched with the wrong shift count.
module hub75_capture #(
  parameter int SCREEN_WIDTH   = hub75_pkg::SCREEN_WIDTH,
  parameter int SCREEN_WIDTH_B = hub75_pkg::SCREEN_WIDTH_B,
  parameter int SCAN_ROWS      = hub75_pkg::SCAN_ROWS,
  parameter bit SAMPLE_FALLING = 1'b1,
  parameter int OE_CNT_W       = 16
) (
  input  logic                              MCLK,
  input  logic                              RESET,
  input  logic                              CLK_MATRIX,
  input  logic                              LATCH,
  input  logic                              OE,
  input  logic [2:0]                        RGB1,
  input  logic [2:0]                        RGB2,
  input  logic [$clog2(SCAN_ROWS)-1:0]      ROW_ADDRESS,
  input  logic [$clog2(2*SCAN_ROWS)-1:0]    rd_row,
  output logic [3*SCREEN_WIDTH-1:0]         rd_data,
  output logic                              frame_done,
  output logic [15:0]                       frame_count,
  output logic [OE_CNT_W-1:0]               oe_low_cycles,
  output logic                              oe_valid,
  output logic                              err_bitcount,
  input  logic                              err_clr
);

  import hub75_pkg::*;

  localparam int ROW_W  = $clog2(SCAN_ROWS);
  localparam int NROWS  = 2 * SCAN_ROWS;
  localparam int IDX_W  = $clog2(SCREEN_WIDTH);
  localparam int BUS_W  = 6 + ROW_W;
  localparam logic [SCREEN_WIDTH_B-1:0] CNT_FULL = SCREEN_WIDTH_B'(SCREEN_WIDTH);
  localparam logic [SCREEN_WIDTH_B-1:0] CNT_SAT  = SCREEN_WIDTH_B'(SCREEN_WIDTH + 1);

  typedef logic [2:0][SCREEN_WIDTH-1:0] row_t;

  logic clk_lvl, clk_rise, clk_fall;
  logic latch_lvl, latch_rise, latch_fall;
  logic oe_lvl, oe_rise, oe_fall;

  hub75_edge_sync #(.RESET_VAL(1'b0)) u_sync_clk (
    .clk_i(MCLK), .rst_i(RESET), .pin_i(CLK_MATRIX),
    .level_o(clk_lvl), .rise_o(clk_rise), .fall_o(clk_fall)
  );

  hub75_edge_sync #(.RESET_VAL(1'b0)) u_sync_latch (
    .clk_i(MCLK), .rst_i(RESET), .pin_i(LATCH),
    .level_o(latch_lvl), .rise_o(latch_rise), .fall_o(latch_fall)
  );

  hub75_edge_sync #(.RESET_VAL(1'b1)) u_sync_oe (
    .clk_i(MCLK), .rst_i(RESET), .pin_i(OE),
    .level_o(oe_lvl), .rise_o(oe_rise), .fall_o(oe_fall)
  );

  logic unused_sync;
  assign unused_sync = clk_lvl ^ latch_fall;

  // Data buses take the same two stages so they align with the edge pulses
  logic [BUS_W-1:0] bus_s1_q, bus_s2_q;
  logic [2:0]       rgb1_s, rgb2_s;
  logic [ROW_W-1:0] row_s;

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      bus_s1_q <= '0;
      bus_s2_q <= '0;
    end else begin
      bus_s1_q <= {RGB1, RGB2, ROW_ADDRESS};
      bus_s2_q <= bus_s1_q;
    end
  end

  assign {rgb1_s, rgb2_s, row_s} = bus_s2_q;

  logic shift_evt;
  assign shift_evt = (SAMPLE_FALLING ? clk_fall : clk_rise) & ~latch_lvl;

  logic [SCREEN_WIDTH_B-1:0] bitcnt_q, bitcnt_d;
  logic [ROW_W-1:0]          held_row_q, held_row_d;
  row_t                      top_q, top_d, bot_q, bot_d;
  logic                      commit_ok, commit_bad;
  logic [IDX_W-1:0]          bit_idx;

  assign bit_idx = bitcnt_q[IDX_W-1:0];

  always_comb begin
    bitcnt_d   = bitcnt_q;
    held_row_d = held_row_q;
    top_d      = top_q;
    bot_d      = bot_q;
    commit_ok  = 1'b0;
    commit_bad = 1'b0;
    if (latch_rise) begin
      bitcnt_d   = '0;
      commit_ok  = (bitcnt_q == CNT_FULL);
      commit_bad = (bitcnt_q != CNT_FULL);
    end else if (shift_evt) begin
      held_row_d = row_s;
      if (bitcnt_q < CNT_FULL) begin
        top_d[COL_R][bit_idx] = rgb1_s[COL_R];
        top_d[COL_G][bit_idx] = rgb1_s[COL_G];
        top_d[COL_B][bit_idx] = rgb1_s[COL_B];
        bot_d[COL_R][bit_idx] = rgb2_s[COL_R];
        bot_d[COL_G][bit_idx] = rgb2_s[COL_G];
        bot_d[COL_B][bit_idx] = rgb2_s[COL_B];
      end
      if (bitcnt_q != CNT_SAT) begin
        bitcnt_d = bitcnt_q + 1'b1;
      end
    end
  end

  logic                frame_done_q, frame_done_d;
  logic [15:0]         frame_count_q, frame_count_d;
  logic                err_q, err_d;
  logic [OE_CNT_W-1:0] oe_cnt_q, oe_cnt_d, oe_low_q, oe_low_d;
  logic                oe_valid_q, oe_valid_d;

  always_comb begin
    frame_done_d  = commit_ok && (held_row_q == ROW_W'(SCAN_ROWS - 1));
    frame_count_d = frame_done_d ? frame_count_q + 16'd1 : frame_count_q;
    err_d         = commit_bad ? 1'b1 : (err_clr ? 1'b0 : err_q);
    // The fall cycle is itself the first low cycle, hence the restart at one
    oe_cnt_d = oe_cnt_q;
    if (oe_fall) begin
      oe_cnt_d = OE_CNT_W'(1);
    end else if (!oe_lvl && (oe_cnt_q != '1)) begin
      oe_cnt_d = oe_cnt_q + 1'b1;
    end
    oe_low_d   = oe_rise ? oe_cnt_q : oe_low_q;
    oe_valid_d = oe_rise;
  end

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      bitcnt_q      <= '0;
      held_row_q    <= '0;
      top_q         <= '0;
      bot_q         <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      err_q         <= 1'b0;
      oe_cnt_q      <= '0;
      oe_low_q      <= '0;
      oe_valid_q    <= 1'b0;
    end else begin
      bitcnt_q      <= bitcnt_d;
      held_row_q    <= held_row_d;
      top_q         <= top_d;
      bot_q         <= bot_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
      err_q         <= err_d;
      oe_cnt_q      <= oe_cnt_d;
      oe_low_q      <= oe_low_d;
      oe_valid_q    <= oe_valid_d;
    end
  end

  // Bottom half lives at held_row + SCAN_ROWS, i.e. the top address bit set
  logic [3*SCREEN_WIDTH-1:0] store_q [NROWS];
  logic [3*SCREEN_WIDTH-1:0] rd_data_q;

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      for (int r = 0; r < NROWS; r++) begin
        store_q[r] <= '0;
      end
      rd_data_q <= '0;
    end else begin
      rd_data_q <= store_q[rd_row];
      if (commit_ok) begin
        store_q[{1'b0, held_row_q}] <= top_q;
        store_q[{1'b1, held_row_q}] <= bot_q;
      end
    end
  end

  assign rd_data       = rd_data_q;
  assign frame_done    = frame_done_q;
  assign frame_count   = frame_count_q;
  assign oe_low_cycles = oe_low_q;
  assign oe_valid      = oe_valid_q;
  assign err_bitcount  = err_q;

endmodule

// File: tb/tb_hub75_capture.sv
// tb/tb_hub75_capture.sv - self-checking bench for hub75_capture
module tb_hub75_capture;

  logic         MCLK = 1'b0;
  logic         RESET = 1'b1;
  logic         CLK_MATRIX = 1'b0;
  logic         LATCH = 1'b0;
  logic         OE = 1'b1;
  logic [2:0]   RGB1 = '0;
  logic [2:0]   RGB2 = '0;
  logic [3:0]   ROW_ADDRESS = '0;
  logic [4:0]   rd_row = '0;
  logic [191:0] rd_data;
  logic         frame_done;
  logic [15:0]  frame_count;
  logic [15:0]  oe_low_cycles;
  logic         oe_valid;
  logic         err_bitcount;
  logic         err_clr = 1'b0;

  always #10 MCLK = ~MCLK;

  hub75_capture dut (
    .MCLK(MCLK), .RESET(RESET), .CLK_MATRIX(CLK_MATRIX), .LATCH(LATCH), .OE(OE),
    .RGB1(RGB1), .RGB2(RGB2), .ROW_ADDRESS(ROW_ADDRESS), .rd_row(rd_row),
    .rd_data(rd_data), .frame_done(frame_done), .frame_count(frame_count),
    .oe_low_cycles(oe_low_cycles), .oe_valid(oe_valid),
    .err_bitcount(err_bitcount), .err_clr(err_clr)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Panel-level model: a row image is what the bench shifted; commits land 3 MCLK after the pin edge
  logic [191:0] m_store [32];
  logic [191:0] sh_top = '0, sh_bot = '0;
  int           nbits = 0;
  logic [3:0]   m_held = '0;
  int           cyc = 0;
  int           lat_edge = -1;
  bit           lat_valid;
  logic [3:0]   lat_row;
  logic [191:0] lat_top, lat_bot;
  int           oe_edge = -1;
  int           oe_val;
  logic [191:0] e_rd = '0;
  logic         e_fd = 1'b0, e_oev = 1'b0, e_err = 1'b0;
  logic [15:0]  e_fc = '0, e_oel = '0;
  bit           chk_en = 1'b0;
  int           fd_seen = 0, oev_seen = 0;

  always @(posedge MCLK) begin
    cyc = cyc + 1;
    e_fd = 1'b0;
    e_oev = 1'b0;
    if (RESET) begin
      foreach (m_store[i]) m_store[i] = '0;
      e_rd = '0; e_fc = '0; e_oel = '0; e_err = 1'b0;
      lat_edge = -1; oe_edge = -1;
    end else begin
      e_rd = m_store[rd_row];
      if (cyc == lat_edge && lat_valid) begin
        m_store[int'(lat_row)] = lat_top;
        m_store[int'(lat_row) + 16] = lat_bot;
        if (lat_row == 4'd15) begin
          e_fd = 1'b1;
          e_fc = e_fc + 16'd1;
        end
      end
      if (cyc == lat_edge && !lat_valid) e_err = 1'b1;
      else if (err_clr) e_err = 1'b0;
      if (cyc == oe_edge) begin
        e_oev = 1'b1;
        e_oel = oe_val[15:0];
      end
    end
  end

  always @(negedge MCLK) begin
    if (chk_en) begin
      check("rd_data", rd_data, e_rd);
      check("frame_done", 192'(frame_done), 192'(e_fd));
      check("frame_count", 192'(frame_count), 192'(e_fc));
      check("oe_valid", 192'(oe_valid), 192'(e_oev));
      check("oe_low_cycles", 192'(oe_low_cycles), 192'(e_oel));
      check("err_bitcount", 192'(err_bitcount), 192'(e_err));
      if (frame_done) fd_seen++;
      if (oe_valid) oev_seen++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge MCLK);
      #1;
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1; CLK_MATRIX = 1'b0; LATCH = 1'b0; OE = 1'b1; err_clr = 1'b0;
    tick(3);
    RESET = 1'b0;
    nbits = 0; m_held = '0; sh_top = '0; sh_bot = '0;
  endtask

  task automatic shift_bit(input logic [2:0] t, input logic [2:0] b, input logic [3:0] addr);
    RGB1 = t; RGB2 = b; ROW_ADDRESS = addr; CLK_MATRIX = 1'b1;
    tick(3);
    CLK_MATRIX = 1'b0;
    if (nbits < 64) begin
      sh_top[128 + nbits] = t[2]; sh_top[64 + nbits] = t[1]; sh_top[nbits] = t[0];
      sh_bot[128 + nbits] = b[2]; sh_bot[64 + nbits] = b[1]; sh_bot[nbits] = b[0];
    end
    nbits++;
    m_held = addr;
    tick(3);
  endtask

  task automatic shift_row(input logic [191:0] top, input logic [191:0] bot,
                           input logic [3:0] addr, input int nb);
    for (int k = 0; k < nb; k++)
      shift_bit({top[128 + k], top[64 + k], top[k]}, {bot[128 + k], bot[64 + k], bot[k]}, addr);
  endtask

  task automatic latch_rise(input logic [3:0] new_addr);
    LATCH = 1'b1;
    ROW_ADDRESS = new_addr;
    lat_valid = (nbits == 64);
    lat_row = m_held;
    lat_top = sh_top;
    lat_bot = sh_bot;
    lat_edge = cyc + 3;
    nbits = 0;
  endtask

  task automatic latch(input logic [3:0] new_addr);
    latch_rise(new_addr);
    tick(4);
    LATCH = 1'b0;
    tick(3);
  endtask

  task automatic oe_pulse(input int n);
    OE = 1'b0;
    tick(n);
    OE = 1'b1;
    oe_val = (n > 65535) ? 65535 : n;
    oe_edge = cyc + 3;
    tick(4);
  endtask

  task automatic read_row(input logic [4:0] r);
    rd_row = r;
    tick(2);
  endtask

  function automatic logic [191:0] pat(input int r, input bit bottom);
    return {64'hF00D_0000_0000_0000 | 64'(r), 64'h1 << r, bottom ? ~64'(r) : 64'(r * 3)};
  endfunction

  logic [191:0] p_top, p_bot;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    chk_en = 1'b1;
    tick(2);

    // 1: B pattern in top half, solid red in bottom half
    p_top = {64'h0, 64'h0, 64'hAAAA_AAAA_AAAA_AAAA};
    p_bot = {64'hFFFF_FFFF_FFFF_FFFF, 128'h0};
    shift_row(p_top, p_bot, 4'd3, 64);
    latch(4'd4);
    read_row(5'd3);
    check("t1_row3_B", 192'(rd_data[63:0]), 192'(64'hAAAA_AAAA_AAAA_AAAA));
    check("t1_row3_RG", 192'(rd_data[191:64]), 192'(0));
    read_row(5'd19);
    check("t1_row19_R", 192'(rd_data[191:128]), 192'(64'hFFFF_FFFF_FFFF_FFFF));
    check("t1_row19_GB", 192'(rd_data[127:0]), 192'(0));

    // 2: short row is discarded and flagged; err_clr clears; full row then commits
    p_top = {64'hDEAD_BEEF_0000_1111, 64'h0, 64'h5555_5555_5555_5555};
    shift_row(p_top, p_top, 4'd5, 63);
    latch(4'd6);
    check("t2_err_set", 192'(err_bitcount), 192'(1));
    read_row(5'd5);
    check("t2_row5_empty", rd_data, 192'(0));
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(1);
    check("t2_err_clr", 192'(err_bitcount), 192'(0));
    p_top = {64'h1357_9BDF_0246_8ACE, 64'hFFFF_0000_FFFF_0000, 64'h0000_0000_0000_0003};
    shift_row(p_top, ~p_top, 4'd5, 64);
    latch(4'd6);
    read_row(5'd5);
    check("t2_row5_commit", rd_data,
          {64'h1357_9BDF_0246_8ACE, 64'hFFFF_0000_FFFF_0000, 64'h0000_0000_0000_0003});
    check("t2_err_after", 192'(err_bitcount), 192'(0));

    // 3: address advances together with LATCH; data must follow the shifted address
    p_top = {64'h0F0F_0F0F_0F0F_0F0F, 64'h00FF_00FF_00FF_00FF, 64'h8421_8421_8421_8421};
    p_bot = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 64'h9999_AAAA_BBBB_CCCC};
    shift_row(p_top, p_bot, 4'd7, 64);
    latch(4'd8);
    read_row(5'd7);
    check("t3_row7", rd_data, p_top);
    read_row(5'd23);
    check("t3_row23", rd_data, p_bot);
    read_row(5'd8);
    check("t3_row8_empty", rd_data, 192'(0));
    read_row(5'd24);
    check("t3_row24_empty", rd_data, 192'(0));

    // 4: OE low window measured in MCLK cycles
    oe_pulse(500);
    check("t4_oe500", 192'(oe_low_cycles), 192'(500));
    check("t4_oe_pulses", 192'(oev_seen), 192'(1));

    // 5: two full frames while a long OE-low window saturates the counter
    fork
      begin
        for (int pass = 1; pass <= 2; pass++) begin
          for (int r = 0; r < 16; r++) begin
            shift_row(pat(r + pass, 1'b0), pat(r + pass, 1'b1), 4'(r), 64);
            latch(4'((r + 1) % 16));
          end
          check("t5_frame_done_count", 192'(fd_seen), 192'(pass));
          check("t5_frame_count", 192'(frame_count), 192'(pass));
        end
      end
      oe_pulse(70000);
    join
    check("t5_oe_sat", 192'(oe_low_cycles), 192'(16'hFFFF));
    check("t5_oe_pulses", 192'(oev_seen), 192'(2));

    // 6: reset mid-row, then a clean row; read-before-write on the commit cycle
    shift_row(pat(9, 1'b0), pat(9, 1'b1), 4'd9, 20);
    do_reset();
    check("t6_err_after_reset", 192'(err_bitcount), 192'(0));
    check("t6_fc_after_reset", 192'(frame_count), 192'(0));
    p_top = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h8000_0000_0000_0001};
    shift_row(p_top, ~p_top, 4'd2, 64);
    rd_row = 5'd2;
    latch_rise(4'd3);
    tick(3);
    check("t6_rbw_old", rd_data, 192'(0));
    tick(1);
    check("t6_rbw_new", rd_data,
          {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h8000_0000_0000_0001});
    LATCH = 1'b0;
    tick(3);
    check("t6_err_clean", 192'(err_bitcount), 192'(0));

    // Latch straight after reset with nothing shifted
    do_reset();
    latch(4'd0);
    check("t7_err_empty_latch", 192'(err_bitcount), 192'(1));
    tick(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
